hazard_flush_controller: RTL

HAZARD_FLUSH_CONTROLLER -- requirements
Module: hazard_flush_controller

---
 rtl/hazard_flush_controller_pkg.sv | 14 +
 rtl/hazard_flush_controller_hazard_detect.sv | 43 ++++
 rtl/hazard_flush_controller.sv | 111 +++++++++++
 3 files changed

// File: rtl/hazard_flush_controller_pkg.sv
// Shared widths and FSM encoding for the hazard/flush controller.
// Imported by the top level and by the hazard-compare sub-module.
package hazard_flush_controller_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/hazard_flush_controller_hazard_detect.sv
// Combinational ID-stage source versus EX/MEM destination comparison.
// Only EX-stage loads stall when forwarding is enabled.
module hazard_detect
  import hazard_flush_controller_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  src1_valid,
  input  logic                  two_src,
  input  logic                  forwarding_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  output logic                  hazard
);

  logic [REG_ADDR_W-1:0] srcs [2];
  logic [1:0]            use_src;
  logic [1:0]            hit;

  assign srcs[0]    = src1;
  assign srcs[1]    = src2;
  assign use_src[0] = src1_valid;
  assign use_src[1] = two_src;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic exe_match;
      logic mem_match;
      // With forwarding, only a load in EX cannot be bypassed in time.
      assign exe_match = exe_wb_en && (srcs[gi] == exe_dest) &&
                         (!forwarding_en || exe_mem_read_en);
      assign mem_match = !forwarding_en && mem_wb_en && (srcs[gi] == mem_dest);
      assign hit[gi]   = use_src[gi] && (exe_match || mem_match);
    end
  endgenerate

  assign hazard = |hit;

endmodule

// File: rtl/hazard_flush_controller.sv
// Pipeline freeze/flush control: MEM-access freeze FSM plus prioritised
// branch flush and data-hazard stall.
module hazard_flush_controller
  import hazard_flush_controller_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  src1_valid,
  input  logic                  two_src,
  input  logic                  forwarding_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  mem_req,
  input  logic                  branch_taken,
  output logic                  freeze_pc,
  output logic                  freeze_if_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  freeze_all
);

  mem_state_t       state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             hazard;
  logic             mem_freeze;

  hazard_detect u_hazard_detect (
    .src1            (src1),
    .src2            (src2),
    .src1_valid      (src1_valid),
    .two_src         (two_src),
    .forwarding_en   (forwarding_en),
    .exe_dest        (exe_dest),
    .exe_wb_en       (exe_wb_en),
    .exe_mem_read_en (exe_mem_read_en),
    .mem_dest        (mem_dest),
    .mem_wb_en       (mem_wb_en),
    .hazard          (hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // The request cycle counts as the first frozen cycle, hence the -2 preload.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_freeze    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_req) begin
          mem_freeze    = 1'b1;
          state_next    = ST_WAIT;
          wait_cnt_next = CNT_W'(MEM_WAIT_CYCLES - 2);
        end
      end
      ST_WAIT: begin
        mem_freeze = 1'b1;
        if (wait_cnt_reg == '0) begin
          state_next = ST_RELEASE;
        end else begin
          wait_cnt_next = wait_cnt_reg - 1'b1;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next    = ST_IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    freeze_all   = 1'b0;
    if (!rst) begin
      if (mem_freeze) begin
        freeze_all   = 1'b1;
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
      end else if (branch_taken) begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
      end else if (hazard) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        flush_id_ex  = 1'b1;
      end
    end
  end

endmodule
